aes_mode_engine: RTL
====================

AES_MODE_ENGINE -- requirements
Module: aes_mode_engine

Interface
REQ-001 Parameter DW, default 32: stream beat width; SHALL be one of 32, 64, 128; BEATS = 128/DW.
REQ-002 Parameter CNT_W, default 16: width of block-count input and counter.
REQ-003 clk_i  in  1  single clock; one clock, all logic on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 clear_i  in  1  synchronous soft clear.
REQ-006 start_i  in  1  job start pulse.
REQ-007 mode_i  in  2  00 ECB, 01 CBC, 10 CTR, 11 reserved; sampled at start.
REQ-008 len_i  in  CNT_W  number of 128-bit blocks; sampled at start.
REQ-009 iv_i  in  128  CBC IV or CTR initial counter; sampled at start.
REQ-010 key_valid_i / key_ready_o / key_data_i  in/out/in  1/1/DW  key stream.
REQ-011 txt_valid_i / txt_ready_o / txt_data_i  in/out/in  1/1/DW  text stream.
REQ-012 out_valid_o / out_ready_i / out_data_o  out/in/out  1/1/DW  result stream.
REQ-013 core_ld_o / core_key_o / core_text_o  out/out/out  1/128/128  cipher-core load.
REQ-014 core_done_i / core_text_i  in/in  1/128  cipher-core result.
REQ-015 busy_o / done_o / cnt_o  out/out/out  1/1/CNT_W  status.

Function
REQ-016 FSM states: IDLE, KEY, GATHER, RUN, EMIT, DONE.
REQ-017 IDLE: on start_i with len_i!=0 latch mode/len/iv, clear cnt_o, go KEY; with len_i==0 go DONE without consuming data.
REQ-018 KEY: key_ready_o=1; accept BEATS beats, first beat into bits [127:128-DW]; after last, go GATHER; key held for whole job.
REQ-019 GATHER: txt_ready_o=1; accept BEATS beats, MS-first; after last handshake go RUN.
REQ-020 RUN: core_ld_o high exactly the first cycle in RUN, core_text_o/core_key_o stable throughout RUN; wait core_done_i, capture result, go EMIT.
REQ-021 ECB: core_text_o = block; result = core_text_i.
REQ-022 CBC: core_text_o = block XOR chain; chain = iv at start, then = core_text_i after each block.
REQ-023 CTR: core_text_o = ctr; result = core_text_i XOR block; ctr = iv at start, +1 modulo 2^128 after each core_ld_o (all-ones wraps to zero).
REQ-024 Mode 11 SHALL behave as ECB.
REQ-025 EMIT: present result MS-first; out_valid_o held with stable data until out_ready_i; no valid drop without handshake.
REQ-026 After last output beat: cnt_o +1; if cnt_o==len go DONE, else GATHER.
REQ-027 DONE: done_o=1 for exactly one cycle, then IDLE.
REQ-028 busy_o=1 in every state except IDLE.
REQ-029 start_i while busy_o SHALL be ignored; core_done_i outside RUN SHALL be ignored.
REQ-030 key_ready_o, txt_ready_o, out_valid_o SHALL be 0 outside KEY, GATHER, EMIT respectively.

Reset
REQ-031 rst_i or clear_i: state IDLE; all outputs 0 (core buses 0); chain, ctr, cnt_o cleared; takes effect next edge even mid-job; clear_i has priority over start_i.

Configuration
REQ-032 Macro AES_MODE_CTR_EN: defined -> CTR per REQ-023; undefined -> no counter/adder logic, mode 10 behaves as ECB.

Verification (core = behavioural AES model, done 10 cycles after ld)
REQ-033 ECB, DW=32, key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff, len=1 -> out 69c4e0d8,6a7b0430,d8cdb780,70b4c55a, then done_o pulse, cnt_o=1.
REQ-034 CBC, iv=0, len=2, both blocks as REQ-033 -> block1 69c4...c55a; block2 core_text_o = 00112233...eeff XOR 69c4e0d8...c55a.
REQ-035 CTR (macro defined), iv=all ones, len=2 -> first core_text_o=ffff...ff, second=0000...00; macro undefined -> mode 10 gives ECB result.
REQ-036 out_ready_i low 5 cycles mid-EMIT -> out_valid_o and out_data_o stable, no beat lost or repeated.
REQ-037 clear_i during RUN, late core_done_i -> stays IDLE, busy_o=0, no output; new job then matches REQ-033.
REQ-038 start_i with len_i=0 -> no ready asserted, done_o one cycle pulse two cycles after start.

Source files
------------

// File: rtl/aes_mode_engine.sv
// aes_mode_engine: AES block-mode wrapper around an external 128-bit cipher core.
// Gathers a key and text blocks from DW-wide streams and runs each block through the core.
// The results go out on a DW-wide stream. Supports ECB, CBC and, optionally, CTR.
// Optional feature macro: AES_MODE_CTR_EN. When it is defined the CTR counter is built.
// When it is undefined, mode 10 runs as ECB.
// Handshake rule, shared by every stream: a beat transfers on a rising edge where
// valid and ready are both 1. Once valid is raised it stays high, with stable data,
// until that transfer happens.
module aes_mode_engine #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic [127:0]     iv_i,
  input  logic             key_valid_i,
  output logic             key_ready_o,
  input  logic [DW-1:0]    key_data_i,
  input  logic             txt_valid_i,
  output logic             txt_ready_o,
  input  logic [DW-1:0]    txt_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [DW-1:0]    out_data_o,
  output logic             core_ld_o,
  output logic [127:0]     core_key_o,
  output logic [127:0]     core_text_o,
  input  logic             core_done_i,
  input  logic [127:0]     core_text_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic [2:0]       state_o
);

  localparam int BEATS = 128 / DW;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KEY    = 3'd1,
    S_GATHER = 3'd2,
    S_RUN    = 3'd3,
    S_EMIT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           state_q;
  logic [1:0]       beat_q;
  logic [127:0]     key_q;
  logic [127:0]     blk_q;
  logic [127:0]     res_q;
  logic [127:0]     chain_q;
  logic [127:0]     core_text_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_cbc_q;
  logic             core_ld_q;
  logic             done_q;
`ifdef AES_MODE_CTR_EN
  logic             is_ctr_q;
  logic [127:0]     ctr_q;
`endif

  logic             last_beat;
  logic [6:0]       beat_lsb;
  logic [127:0]     key_nxt;
  logic [127:0]     blk_nxt;
  logic [127:0]     core_in;
  logic [127:0]     res_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             key_hs;
  logic             txt_hs;
  logic             out_hs;

  // Stream readiness and status are decoded straight from the state register
  assign key_ready_o = (state_q == S_KEY);
  assign txt_ready_o = (state_q == S_GATHER);
  assign out_valid_o = (state_q == S_EMIT);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign core_ld_o   = core_ld_q;
  assign core_key_o  = key_q;
  assign core_text_o = core_text_q;
  assign cnt_o       = cnt_q;
  assign state_o     = state_q;

  assign key_hs    = key_valid_i && key_ready_o;
  assign txt_hs    = txt_valid_i && txt_ready_o;
  assign out_hs    = out_valid_o && out_ready_i;
  assign last_beat = (beat_q == 2'(BEATS - 1));
  assign cnt_inc   = cnt_q + CNT_W'(1);

  // Beat 0 maps to the most significant DW bits of a 128-bit block
  assign beat_lsb = 7'(128 - DW * (int'(beat_q) + 1));

  // Slot the incoming beat into the block, pick the core input and the block result
  always_comb begin
    key_nxt = key_q;
    key_nxt[beat_lsb +: DW] = key_data_i;
    blk_nxt = blk_q;
    blk_nxt[beat_lsb +: DW] = txt_data_i;
    core_in = blk_nxt;
    res_nxt = core_text_i;
    if (is_cbc_q) begin
      core_in = blk_nxt ^ chain_q;
    end
`ifdef AES_MODE_CTR_EN
    if (is_ctr_q) begin
      core_in = ctr_q;
      res_nxt = core_text_i ^ blk_q;
    end
`endif
  end

  // Result stream: only drive data while a beat is being offered
  always_comb begin
    out_data_o = '0;
    if (state_q == S_EMIT) begin
      out_data_o = res_q[beat_lsb +: DW];
    end
  end

  // Job sequencer: key load, then per block gather -> core run -> emit
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      key_q       <= '0;
      blk_q       <= '0;
      res_q       <= '0;
      chain_q     <= '0;
      core_text_q <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      is_cbc_q    <= 1'b0;
      core_ld_q   <= 1'b0;
      done_q      <= 1'b0;
`ifdef AES_MODE_CTR_EN
      is_ctr_q    <= 1'b0;
      ctr_q       <= '0;
`endif
    end else begin
      core_ld_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              len_q    <= len_i;
              cnt_q    <= '0;
              chain_q  <= iv_i;
              is_cbc_q <= (mode_i == 2'b01);
`ifdef AES_MODE_CTR_EN
              is_ctr_q <= (mode_i == 2'b10);
              ctr_q    <= iv_i;
`endif
              beat_q   <= '0;
              state_q  <= S_KEY;
            end else begin
              state_q  <= S_DONE;
            end
          end
        end
        S_KEY: begin
          if (key_hs) begin
            key_q <= key_nxt;
            if (last_beat) begin
              beat_q  <= '0;
              state_q <= S_GATHER;
            end else begin
              beat_q <= beat_q + 2'd1;
            end
          end
        end
        S_GATHER: begin
          if (txt_hs) begin
            blk_q <= blk_nxt;
            if (last_beat) begin
              beat_q      <= '0;
              core_text_q <= core_in;
              core_ld_q   <= 1'b1;
`ifdef AES_MODE_CTR_EN
              if (is_ctr_q) begin
                ctr_q <= ctr_q + 128'd1;
              end
`endif
              state_q     <= S_RUN;
            end else begin
              beat_q <= beat_q + 2'd1;
            end
          end
        end
        S_RUN: begin
          if (core_done_i) begin
            res_q <= res_nxt;
            if (is_cbc_q) begin
              chain_q <= core_text_i;
            end
            state_q <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_hs) begin
            if (last_beat) begin
              beat_q <= '0;
              cnt_q  <= cnt_inc;
              state_q <= (cnt_inc == len_q) ? S_DONE : S_GATHER;
            end else begin
              beat_q <= beat_q + 2'd1;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
